// File: rtl/ann_sched_pkg.sv
// Shared types and defaults for the ANN job scheduler.
package ann_sched_pkg;

    localparam int unsigned LABEL_W_DEF        = 32;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 8192;

    // Label reported when a job is ended by the watchdog rather than the core.
    localparam logic [LABEL_W_DEF-1:0] ERR_LABEL_DEF = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/ann_job_scheduler_if.sv
// Requester-facing request/response bundle for the ANN job scheduler.
interface ann_job_scheduler_if #(
    parameter int unsigned LABEL_W = 32
);
    logic               req0_valid;
    logic               req0_ready;
    logic               req1_valid;
    logic               req1_ready;
    logic               resp0_valid;
    logic               resp0_ready;
    logic               resp1_valid;
    logic               resp1_ready;
    logic [LABEL_W-1:0] resp_label;
    logic               resp_err;

    // Requester side.
    modport master (
        output req0_valid, req1_valid, resp0_ready, resp1_ready,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_label, resp_err
    );

    // Scheduler side.
    modport slave (
        input  req0_valid, req1_valid, resp0_ready, resp1_ready,
        output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_label, resp_err
    );
endinterface

// File: rtl/ann_rr_arbiter.sv
// Two-way round-robin arbiter; pointer advances only when a grant is accepted.
module ann_rr_arbiter (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic gnt0_c,
    output logic gnt1_c
);
    // 1 means requester 1 was granted last, so requester 0 wins the next tie.
    logic last_q;

    // Lone requester always wins; on a tie, the one not granted last wins.
    always_comb begin
        gnt0_c = req0 & (~req1 | last_q);
        gnt1_c = req1 & (~req0 | ~last_q);
    end

    // Remember who was served on every accepted grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= gnt1_c;
        end
    end
endmodule

// File: rtl/ann_job_scheduler.sv
// ANN job scheduler: arbitrates two requesters onto one ANN core and returns
// the label on the winner's response channel.
// Optional build macro ANN_TIMEOUT_EN adds a WAIT-state watchdog.
import ann_sched_pkg::*;

module ann_job_scheduler #(
    parameter int unsigned LABEL_W        = LABEL_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clock,
    input  logic               reset,
    ann_job_scheduler_if.slave bus,
    output logic               core_start,
    input  logic               core_done,
    input  logic [LABEL_W-1:0] core_result,
    output logic               busy,
    output logic [15:0]        jobs_done
);
    sched_state_e       state_q, next_state;
    logic               owner_q;
    logic               core_start_q, busy_q, resp0_valid_q, resp1_valid_q;
    logic [LABEL_W-1:0] label_q;
    logic [15:0]        jobs_done_q;
    logic               gnt0_c, gnt1_c;
    logic               accept_c, capture_c, consume_c, timeout_c;

    ann_rr_arbiter u_arb (
        .clock  (clock),
        .reset  (reset),
        .req0   (bus.req0_valid),
        .req1   (bus.req1_valid),
        .accept (accept_c),
        .gnt0_c (gnt0_c),
        .gnt1_c (gnt1_c)
    );

    // Next-state and handshake decode.
    always_comb begin
        next_state = state_q;
        accept_c   = 1'b0;
        capture_c  = 1'b0;
        consume_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req0_valid | bus.req1_valid) begin
                    accept_c   = 1'b1;
                    next_state = ST_START;
                end
            end
            ST_START: next_state = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    capture_c  = 1'b1;
                    next_state = ST_RESP;
                end else if (timeout_c) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (owner_q ? bus.resp1_ready : bus.resp0_ready) begin
                    consume_c  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register plus outputs registered from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            core_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            state_q       <= next_state;
            if (accept_c) begin
                owner_q <= gnt1_c;
            end
            core_start_q  <= (next_state == ST_START);
            busy_q        <= (next_state != ST_IDLE);
            resp0_valid_q <= (next_state == ST_RESP) & ~owner_q;
            resp1_valid_q <= (next_state == ST_RESP) &  owner_q;
        end
    end

    // Response label: core result on completion, all-ones on watchdog expiry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            label_q <= '0;
        end else if (capture_c) begin
            label_q <= core_result;
        end else if ((state_q == ST_WAIT) && timeout_c) begin
            label_q <= '1;
        end
    end

    // Completed-job counter, wraps naturally at 16 bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jobs_done_q <= '0;
        end else if (consume_c) begin
            jobs_done_q <= jobs_done_q + 16'(1);
        end
    end

`ifdef ANN_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    assign timeout_c = (state_q == ST_WAIT) && !core_done &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // WAIT cycle counter; held at zero outside WAIT so it restarts on entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (state_q != ST_WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    // Error flag accompanies the label that was captured with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (capture_c) begin
            err_q <= 1'b0;
        end else if ((state_q == ST_WAIT) && timeout_c) begin
            err_q <= 1'b1;
        end
    end

    assign bus.resp_err = err_q;
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign timeout_c          = 1'b0;
    assign bus.resp_err       = 1'b0;
`endif

    assign bus.req0_ready  = accept_c & gnt0_c;
    assign bus.req1_ready  = accept_c & gnt1_c;
    assign bus.resp0_valid = resp0_valid_q;
    assign bus.resp1_valid = resp1_valid_q;
    assign bus.resp_label  = label_q;
    assign core_start      = core_start_q;
    assign busy            = busy_q;
    assign jobs_done       = jobs_done_q;
endmodule

// File: tb/tb_ann_job_scheduler.sv
// Randomized self-checking bench for ann_job_scheduler with a transaction-level model.
module tb_ann_job_scheduler;
    import ann_sched_pkg::*;

    localparam int unsigned LW = 32;
    localparam int unsigned TO = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          core_start;
    logic          core_done;
    logic [LW-1:0] core_result;
    logic          busy;
    logic [15:0]   jobs_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: who was served last, job count, last delivered label.
    bit          exp_last  = 1'b1;
    logic [15:0] exp_jobs  = 16'h0;
    logic [31:0] exp_label = 32'h0;

    ann_job_scheduler_if #(.LABEL_W(LW)) bus ();

    ann_job_scheduler #(.LABEL_W(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_result (core_result),
        .busy        (busy),
        .jobs_done   (jobs_done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic quiet_inputs();
        bus.req0_valid  = 1'b0;
        bus.req1_valid  = 1'b0;
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        core_done       = 1'b0;
        core_result     = '0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_busy",   32'(busy), 0);
        check_eq("rst_start",  32'(core_start), 0);
        check_eq("rst_rdy0",   32'(bus.req0_ready), 0);
        check_eq("rst_rdy1",   32'(bus.req1_ready), 0);
        check_eq("rst_rv0",    32'(bus.resp0_valid), 0);
        check_eq("rst_rv1",    32'(bus.resp1_valid), 0);
        check_eq("rst_label",  bus.resp_label, 0);
        check_eq("rst_err",    32'(bus.resp_err), 0);
        check_eq("rst_jobs",   32'(jobs_done), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        quiet_inputs();
        reset = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clock);
        reset     = 1'b0;
        exp_last  = 1'b1;
        exp_jobs  = 16'h0;
        exp_label = 32'h0;
    endtask

    // One full job: request, optional early done during START, core latency,
    // response hold with blocked requests, then consumption.
    task automatic run_job(input bit v0, input bit v1, input int dly,
                           input logic [31:0] res, input int hold, input bit early_done);
        int g;
        @(negedge clock);
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        #1;
        g = (v0 && v1) ? (exp_last ? 0 : 1) : (v1 ? 1 : 0);
        check_eq("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
        check_eq("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
        check_eq("idle_busy", 32'(busy), 0);
        exp_last = (g == 1);

        @(negedge clock);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check_eq("core_start", 32'(core_start), 1);
        check_eq("start_busy", 32'(busy), 1);
        if (early_done) begin
            core_done   = 1'b1;
            core_result = ~res;
        end

        @(negedge clock);
        core_done = 1'b0;
        check_eq("start_pulse_end", 32'(core_start), 0);
        for (int i = 0; i < dly; i++) begin
            check_eq("wait_rv0", 32'(bus.resp0_valid), 0);
            check_eq("wait_rv1", 32'(bus.resp1_valid), 0);
            @(negedge clock);
        end
        core_done   = 1'b1;
        core_result = res;
        @(negedge clock);
        core_done   = 1'b0;
        core_result = $urandom;
        exp_label   = res;
        check_eq("resp0_valid", 32'(bus.resp0_valid), 32'(g == 0));
        check_eq("resp1_valid", 32'(bus.resp1_valid), 32'(g == 1));
        check_eq("resp_label", bus.resp_label, exp_label);
        check_eq("resp_err", 32'(bus.resp_err), 0);

        for (int i = 0; i < hold; i++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            #1;
            check_eq("hold_rdy0", 32'(bus.req0_ready), 0);
            check_eq("hold_rdy1", 32'(bus.req1_ready), 0);
            check_eq("hold_start", 32'(core_start), 0);
            check_eq("hold_rv", 32'(g == 0 ? bus.resp0_valid : bus.resp1_valid), 1);
            check_eq("hold_label", bus.resp_label, exp_label);
            @(negedge clock);
        end

        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        if (g == 0) bus.resp0_ready = 1'b1;
        else        bus.resp1_ready = 1'b1;
        #1;
        check_eq("done_cycle_rdy0", 32'(bus.req0_ready), 0);
        check_eq("done_cycle_rdy1", 32'(bus.req1_ready), 0);

        @(negedge clock);
        quiet_inputs();
        exp_jobs = exp_jobs + 16'(1);
        check_eq("jobs_done", 32'(jobs_done), 32'(exp_jobs));
        check_eq("post_rv0", 32'(bus.resp0_valid), 0);
        check_eq("post_rv1", 32'(bus.resp1_valid), 0);
        check_eq("post_busy", 32'(busy), 0);
        check_eq("label_kept", bus.resp_label, exp_label);
    endtask

    initial begin
        quiet_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check_reset_outputs();
        @(negedge clock);
        reset = 1'b0;

        // Single requester, result 7.
        run_job(1'b1, 1'b0, 2, 32'd7, 0, 1'b0);

        // Contention right after reset: expected order 0,1,0.
        do_reset();
        for (int j = 0; j < 3; j++) begin
            run_job(1'b1, 1'b1, 1, $urandom, 0, 1'b0);
        end

        // Long response stall on channel 1.
        run_job(1'b0, 1'b1, 1, $urandom, 20, 1'b0);

        // Randomized traffic.
        for (int j = 0; j < 40; j++) begin
            int pat;
            pat = int'($urandom_range(1, 3));
            run_job(pat[0], pat[1], int'($urandom_range(0, 6)), $urandom,
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset while the core is busy; a late done must be ignored.
        @(negedge clock);
        bus.req1_valid = 1'b1;
        @(negedge clock);
        bus.req1_valid = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("midwait_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clock);
        reset     = 1'b0;
        exp_last  = 1'b1;
        exp_jobs  = 16'h0;
        exp_label = 32'h0;
        core_done   = 1'b1;
        core_result = 32'd55;
        @(negedge clock);
        core_done = 1'b0;
        repeat (3) begin
            check_eq("late_done_busy", 32'(busy), 0);
            check_eq("late_done_rv0", 32'(bus.resp0_valid), 0);
            check_eq("late_done_rv1", 32'(bus.resp1_valid), 0);
            check_eq("late_done_jobs", 32'(jobs_done), 0);
            check_eq("late_done_label", bus.resp_label, 0);
            @(negedge clock);
        end
        run_job(1'b1, 1'b1, 0, $urandom, 1, 1'b0);

        // Counter wrap.
        @(negedge clock);
        force dut.jobs_done_q = 16'hFFFF;
        #1;
        release dut.jobs_done_q;
        exp_jobs = 16'hFFFF;
        @(negedge clock);
        check_eq("jobs_forced", 32'(jobs_done), 32'h0000_FFFF);
        run_job(1'b0, 1'b1, 3, $urandom, 0, 1'b0);
        check_eq("jobs_wrapped", 32'(jobs_done), 0);

        // Core never completes.
        @(negedge clock);
        bus.req0_valid = 1'b1;
        #1;
        check_eq("to_rdy0", 32'(bus.req0_ready), 1);
        exp_last = 1'b0;
        @(negedge clock);
        bus.req0_valid = 1'b0;
        check_eq("to_start", 32'(core_start), 1);
`ifdef ANN_TIMEOUT_EN
        for (int i = 0; i < int'(TO); i++) begin
            @(negedge clock);
            check_eq("to_wait_rv0", 32'(bus.resp0_valid), 0);
        end
        @(negedge clock);
        check_eq("to_rv0", 32'(bus.resp0_valid), 1);
        check_eq("to_rv1", 32'(bus.resp1_valid), 0);
        check_eq("to_label", bus.resp_label, 32'hFFFF_FFFF);
        check_eq("to_err", 32'(bus.resp_err), 1);
        bus.resp0_ready = 1'b1;
        @(negedge clock);
        bus.resp0_ready = 1'b0;
        exp_jobs = exp_jobs + 16'(1);
        check_eq("to_jobs", 32'(jobs_done), 32'(exp_jobs));
        check_eq("to_busy", 32'(busy), 0);
`else
        repeat (1000) @(negedge clock);
        check_eq("nto_busy", 32'(busy), 1);
        check_eq("nto_rv0", 32'(bus.resp0_valid), 0);
        check_eq("nto_err", 32'(bus.resp_err), 0);
        check_eq("nto_jobs", 32'(jobs_done), 32'(exp_jobs));
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
